// File: rtl/counter.sv
// Two-digit BCD stopwatch counter: a prescaler divides clk into a tick that advances the packed BCD reading.
// Optional COUNTER_SATURATE_EN: the reading holds at 8'h99 instead of wrapping to 8'h00.
module counter #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       count_enabled,
  output logic [7:0] time_reading
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  if (TICK_CYCLES < 2 || CLK_FREQ < 1) begin : g_bad_params
    $error("counter: TICK_CYCLES must be >= 2 and CLK_FREQ positive");
  end

  logic [PW-1:0] presc;
  logic [3:0]    low;
  logic [3:0]    high;
  logic [3:0]    low_next;
  logic [3:0]    high_next;
  logic          tick;

  // A tick needs the enable on the wrap edge; a paused wrap edge leaves presc at LAST.
  assign tick = count_enabled && (presc == LAST);

  always_comb begin
    low_next  = low;
    high_next = high;
    if (tick && !(SATURATE && high == 4'd9 && low == 4'd9)) begin
      if (low == 4'd9) begin
        low_next  = '0;
        high_next = (high == 4'd9) ? '0 : high + 4'd1;
      end else begin
        low_next  = low + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge init_regs) begin
    if (!init_regs) begin
      presc <= '0;
      low   <= '0;
      high  <= '0;
    end else if (count_enabled) begin
      presc <= tick ? '0 : presc + PW'(1);
      low   <= low_next;
      high  <= high_next;
    end
  end

  assign time_reading = {high, low};

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter with a short tick period; a reference model of elapsed
// enabled edges feeds a scoreboard of expected readings compared one cycle later.
module tb_counter;

  localparam int T = 4;

  logic       clk;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] time_reading;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned en_edges     = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp;

  counter #(.CLK_FREQ(100_000_000), .TICK_CYCLES(T)) dut (
    .clk           (clk),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .time_reading  (time_reading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] model_reading(int unsigned edges);
    int unsigned ticks;
    ticks = edges / T;
`ifdef COUNTER_SATURATE_EN
    if (ticks > 99) ticks = 99;
`else
    ticks = ticks % 100;
`endif
    return {4'(ticks / 10), 4'(ticks % 10)};
  endfunction

  // Called at posedge+1: set inputs, predict the post-edge reading, advance one clock.
  task automatic drive(input logic en);
    count_enabled = en;
    if (init_regs && en) en_edges++;
    sb.push_back(model_reading(en_edges));
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int unsigned cycles);
    init_regs = 1'b0;
    en_edges  = 0;
    for (int i = 0; i < cycles; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL reset_hold: time_reading=%h expected=%h", time_reading, exp);
      end
    end
    init_regs = 1'b1;
  endtask

  task automatic test_reset;
    init_regs     = 1'b0;
    count_enabled = 1'b1;
    #2;
    tests_run++;
    if (time_reading !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: time_reading=%h expected=00", time_reading);
    end
    @(posedge clk);
    #1;
    hold_reset(5);
  endtask

  task automatic test_first_tick;
    hold_reset(2);
    for (int i = 0; i < 2 * T + 1; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL first_tick edge %0d: time_reading=%h expected=%h", i + 1, time_reading, exp);
      end
    end
  endtask

  task automatic test_bcd_carry;
    hold_reset(2);
    for (int i = 0; i < 45 * T; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp || time_reading[3:0] > 4'd9) begin
        tests_failed++;
        $display("FAIL bcd_carry edge %0d: time_reading=%h expected=%h", i + 1, time_reading, exp);
      end
      if (i == 36 * T - 1) begin
        tests_run++;
        if (time_reading !== 8'h36) begin
          tests_failed++;
          $display("FAIL bcd_36: time_reading=%h expected=36", time_reading);
        end
      end
    end
    tests_run++;
    if (time_reading !== 8'h45) begin
      tests_failed++;
      $display("FAIL bcd_45: time_reading=%h expected=45", time_reading);
    end
  endtask

  task automatic test_pause;
    logic [7:0] frozen;
    hold_reset(2);
    for (int i = 0; i < 3 * T + 2; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL pause_run: time_reading=%h expected=%h", time_reading, exp);
      end
    end
    frozen = model_reading(en_edges);
    for (int i = 0; i < 50; i++) begin
      drive(1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL pause_hold cycle %0d: time_reading=%h expected=%h", i, time_reading, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL pause_resume edge %0d: time_reading=%h expected=%h", i + 1, time_reading, exp);
      end
    end
    tests_run++;
    if (time_reading !== frozen + 8'h01) begin
      tests_failed++;
      $display("FAIL pause_phase: time_reading=%h expected=%h", time_reading, frozen + 8'h01);
    end
  endtask

  task automatic test_wrap;
    hold_reset(2);
    for (int i = 0; i < 100 * T + 2; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL wrap edge %0d: time_reading=%h expected=%h", i + 1, time_reading, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    hold_reset(2);
    for (int i = 0; i < 57 * T + 2; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL async_run: time_reading=%h expected=%h", time_reading, exp);
      end
    end
    tests_run++;
    if (time_reading !== 8'h57) begin
      tests_failed++;
      $display("FAIL async_pre: time_reading=%h expected=57", time_reading);
    end
    #1 init_regs = 1'b0;
    #1;
    tests_run++;
    if (time_reading !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_clear: time_reading=%h expected=00", time_reading);
    end
    @(posedge clk);
    #1;
    hold_reset(1);
    for (int i = 0; i < T + 1; i++) begin
      drive(1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL async_restart edge %0d: time_reading=%h expected=%h", i + 1, time_reading, exp);
      end
    end
  endtask

  task automatic test_hold_disabled;
    hold_reset(2);
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (time_reading !== exp) begin
        tests_failed++;
        $display("FAIL hold_disabled cycle %0d: time_reading=%h expected=%h", i, time_reading, exp);
      end
    end
  endtask

  initial begin
    init_regs     = 1'b0;
    count_enabled = 1'b0;
    test_reset();
    test_first_tick();
    test_bcd_carry();
    test_pause();
    test_wrap();
    test_async_reset();
    test_hold_disabled();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
